// File: rtl/sr_encode.sv
// RV32I instruction encoder: packs opcode/register/funct fields and a byte-offset immediate into a 32-bit word.
// Latency: 1 cycle from input accept to output when the buffer is empty; 1 word/cycle sustained.
// Backpressure: 2-entry skid buffer (main + skid); registered in_ready drops only when both entries are full.
//
// Ports: clk/rst (synchronous, active-high); in_* valid/ready field input; out_* valid/ready word output
//        carrying out_instr, out_addr (word address) and out_err (encoding error).
// Optional feature macro: SR_ENCODE_IMM_CHECK_EN (flag immediates that do not fit the format).
module sr_encode #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned ADDR_START = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_f3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [6:0]        in_f7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(ADDR_START);

  // Everything that belongs to one output word moves through the buffer as a unit.
  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } word_t;

  localparam word_t WORD_RST = '{instr: 32'h0, addr: START_ADDR, err: 1'b0};

  logic              in_xfer;
  logic              out_xfer;
  logic [31:0]       enc_instr;
  logic              enc_err;
  word_t             enc_word;

  word_t             main_q, main_d;
  word_t             skid_q, skid_d;
  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic              in_rdy_q, in_rdy_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;

  assign in_xfer  = in_valid & in_rdy_q;
  assign out_xfer = main_vld_q & out_ready;

  // Field placement per format.
  always_comb begin
    enc_instr = {in_f7, in_rs2, in_rs1, in_f3, in_rd, in_op};
    enc_err   = 1'b0;
    case (in_fmt)
      3'd0: enc_instr = {in_f7, in_rs2, in_rs1, in_f3, in_rd, in_op};
      3'd1: enc_instr = {in_imm[11:0], in_rs1, in_f3, in_rd, in_op};
      3'd2: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], in_op};
      3'd3: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3,
                         in_imm[4:1], in_imm[11], in_op};
      3'd4: enc_instr = {in_imm[31:12], in_rd, in_op};
      3'd5: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
      default: begin
        // Illegal format: still produce an R-shaped word so the stream stays aligned.
        enc_instr = {in_f7, in_rs2, in_rs1, in_f3, in_rd, in_op};
        enc_err   = 1'b1;
      end
    endcase
`ifdef SR_ENCODE_IMM_CHECK_EN
    // An immediate fits when every bit above the format's sign bit equals that sign bit.
    case (in_fmt)
      3'd1, 3'd2: enc_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      3'd3:       enc_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      3'd4:       enc_err = |in_imm[11:0];
      3'd5:       enc_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      3'd0:       enc_err = 1'b0;
      default:    enc_err = 1'b1;
    endcase
`endif
  end

  // The address is bound to the word when it is accepted, not when it leaves.
  assign enc_word = '{instr: enc_instr, addr: addr_cnt_q, err: enc_err};

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    addr_cnt_d = in_xfer ? addr_cnt_q + 1'b1 : addr_cnt_q;

    if (!main_vld_q || out_xfer) begin
      // Main register is free this cycle: refill from the skid entry first to keep order.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = in_xfer;
        if (in_xfer) begin
          skid_d = enc_word;
        end
      end else begin
        main_vld_d = in_xfer;
        if (in_xfer) begin
          main_d = enc_word;
        end
      end
    end else if (in_xfer) begin
      // Main is stalled; the skid entry absorbs the one word in flight.
      skid_d     = enc_word;
      skid_vld_d = 1'b1;
    end

    // Registered ready looks at next-cycle occupancy, so it never over-accepts.
    in_rdy_d = !(main_vld_d && skid_vld_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= WORD_RST;
      skid_q     <= WORD_RST;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
      addr_cnt_q <= START_ADDR;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
      addr_cnt_q <= addr_cnt_d;
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = main_vld_q;
  assign out_instr = main_q.instr;
  assign out_addr  = main_q.addr;
  assign out_err   = main_q.err;

endmodule

// File: tb/tb_sr_encode.sv
// Bench for sr_encode: directed literal words plus randomized traffic against a queue-based model.
// Latency/backpressure are checked through the model's occupancy every cycle.
// Randomized in_valid/out_ready exercise stalls, skid capture and occasional resets.
module tb_sr_encode;

  localparam int AW = 2;
  localparam int AS = 0;

`ifdef SR_ENCODE_IMM_CHECK_EN
  localparam bit IMMCHK = 1'b1;
`else
  localparam bit IMMCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_op = '0;
  logic [4:0]    in_rd = '0;
  logic [2:0]    in_f3 = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [6:0]    in_f7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err;

  always #5 clk = ~clk;

  sr_encode #(.ADDR_W(AW), .ADDR_START(AS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_rd(in_rd), .in_f3(in_f3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_f7(in_f7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    bit          lit_vld;
    logic [31:0] lit_instr;
    logic        lit_err;
  } exp_t;

  exp_t        q[$];
  int          exp_addr = AS;
  int          pass_cnt = 0;
  int          chk_cnt = 0;
  bit          after_rst = 1'b0;
  bit          lit_vld = 1'b0;
  logic [31:0] lit_instr = '0;
  logic        lit_err = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
  endfunction

  // Reference encoding written as shift/mask arithmetic on the ISA field layout.
  function automatic logic [31:0] m_instr(int unsigned fmt, int unsigned op, int unsigned rd,
                                          int unsigned f3, int unsigned rs1, int unsigned rs2,
                                          int unsigned f7, int unsigned imm);
    int unsigned w;
    w = op;
    case (fmt)
      1: w = w | ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7);
      2: w = w | (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
               | ((imm & 32'h1F) << 7);
      3: w = w | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
               | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
      4: w = w | (imm & 32'hFFFFF000) | (rd << 7);
      5: w = w | (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
               | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7);
      default: w = w | (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7);
    endcase
    return w;
  endfunction

  // Representability expressed as signed ranges and divisibility.
  function automatic logic m_err(int unsigned fmt, int unsigned imm);
    int s;
    s = int'(imm);
    if (fmt > 5) return 1'b1;
    if (!IMMCHK) return 1'b0;
    case (fmt)
      1, 2: return !(s >= -2048 && s <= 2047);
      3:    return !(s >= -4096 && s <= 4095 && (s % 2) == 0);
      4:    return (imm % 4096) != 0;
      5:    return !(s >= -(1 << 20) && s < (1 << 20) && (s % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Single compare process: checks outputs against the model, then advances the model
  // with the transfers that will happen at the coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      exp_addr  = AS;
      after_rst = 1'b1;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (after_rst) begin
        chk("reset_instr", out_instr, 32'h0);
        chk("reset_err", 32'(out_err), 32'h0);
        chk("reset_addr", 32'(out_addr), 32'(AS));
        after_rst = 1'b0;
      end
      if (out_valid && q.size() > 0) begin
        chk("out_instr", out_instr, q[0].instr);
        chk("out_addr", 32'(out_addr), q[0].addr);
        chk("out_err", 32'(out_err), 32'(q[0].err));
        if (q[0].lit_vld) begin
          chk("lit_instr", out_instr, q[0].lit_instr);
          chk("lit_err", 32'(out_err), 32'(q[0].lit_err));
        end
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e.instr     = m_instr(in_fmt, in_op, in_rd, in_f3, in_rs1, in_rs2, in_f7, in_imm);
        e.err       = m_err(in_fmt, in_imm);
        e.addr      = 32'(exp_addr);
        e.lit_vld   = lit_vld;
        e.lit_instr = lit_instr;
        e.lit_err   = lit_err;
        if (lit_vld) begin
          chk("model_pin_instr", e.instr, lit_instr);
          chk("model_pin_err", 32'(e.err), 32'(lit_err));
        end
        q.push_back(e);
        exp_addr = (exp_addr + 1) % (1 << AW);
      end
    end
  end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input bit lv, input logic [31:0] li, input logic le);
    bit acc;
    int n;
    in_fmt = fmt; in_op = op; in_rd = rd; in_f3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_f7 = f7; in_imm = imm;
    lit_vld = lv; lit_instr = li; lit_err = le;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    in_valid = 1'b0;
    lit_vld  = 1'b0;
    if (!acc) begin
      $display("FAIL send_timeout: actual in_ready 0 for %0d cycles required 1", n);
      $fatal(1, "input handshake never completed");
    end
  endtask

  function automatic logic [31:0] rnd_imm();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return 32'($urandom_range(0, 4095)) << 12;
      3: return 32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000;
      default: begin
        case ($urandom_range(0, 7))
          0: return 32'd2047;
          1: return 32'd2048;
          2: return -32'd2048;
          3: return -32'd2049;
          4: return 32'd4094;
          5: return 32'd4096;
          6: return 32'h000FFFFE;
          default: return 32'h00100000;
        endcase
      end
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed words with hand-computed encodings.
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1, 32'h00500093, 1'b0);
    send(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1, 32'h002081B3, 1'b0);
    send(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, -32'd4, 1, 32'hFE208EE3, 1'b0);
    send(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1, 32'h123452B7, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8, 1, 32'h008000EF, 1'b0);
    send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1, 32'h80000093, IMMCHK);
    send(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3, 1, 32'h00208163, IMMCHK);
    send(3'd6, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1, 32'h002081B3, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Stall: four words queued against a blocked output, then released; a fifth wraps the address.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(3'd1, 7'h13, 5'(i + 1), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i), 0, 32'h0, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    send(3'd4, 7'h37, 5'd7, 3'd0, 5'd0, 5'd0, 7'd0, 32'hABCDE000, 0, 32'h0, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Reset while two words are held.
    out_ready = 1'b0;
    send(3'd0, 7'h33, 5'd4, 3'd1, 5'd2, 5'd3, 7'h20, 32'd0, 0, 32'h0, 1'b0);
    send(3'd2, 7'h23, 5'd0, 3'd2, 5'd2, 5'd3, 7'd0, 32'd12, 0, 32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b1;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      rst       = ($urandom_range(0, 499) == 0);
      in_fmt    = 3'($urandom_range(0, 7));
      in_op     = 7'($urandom);
      in_rd     = 5'($urandom);
      in_f3     = 3'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_f7     = 7'($urandom);
      in_imm    = rnd_imm();
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sr_encode.md
Name: sr_encode

Overview:
- Streaming RISC-V RV32I instruction encoder; the inverse of the decode stage.
- Packs opcode, register and funct fields plus a byte-offset immediate into a 32-bit instruction word for a given format (R/I/S/B/U/J).
- Uses a valid/ready handshake with a 2-entry skid buffer and a word-address counter, so a test program generator or loader can stream words into instruction memory at one word per cycle.

Parameters:
- ADDR_W, 8, width of the output word-address counter; wraps modulo 2^ADDR_W.
- ADDR_START, 0, word address loaded into out_addr at reset.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder can accept; registered
- in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_op  input  7  opcode -> instr[6:0]
- in_rd  input  5  -> instr[11:7] (R/I/U/J)
- in_f3  input  3  -> instr[14:12] (R/I/S/B)
- in_rs1  input  5  -> instr[19:15] (R/I/S/B)
- in_rs2  input  5  -> instr[24:20] (R/S/B)
- in_f7  input  7  -> instr[31:25] (R only)
- in_imm  input  32  immediate as byte value or offset, two's complement
- out_valid  output  1  out_instr/out_addr/out_err valid
- out_ready  input  1  downstream accepts
- out_instr  output  32  encoded instruction
- out_addr  output  ADDR_W  word address of this instruction
- out_err  output  1  encoding error flag for this word

Behaviour:
- Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
- Reset (synchronous, overrides everything):
  - out_valid=0, in_ready=1, out_instr=0, out_err=0, out_addr=ADDR_START.
  - Both buffer entries are emptied; a reset mid-stream discards held words.
- Latency: an input accepted in cycle N appears at the outputs in cycle N+1 when the buffer was empty.
- Throughput is 1 word/cycle while out_ready=1. Words are delivered in order, with none dropped or duplicated.
- Skid buffer:
  - Main output register plus one skid entry.
  - in_ready is registered, and deasserts only when both entries are occupied.
  - When out_ready drops, at most one extra word is captured, in the skid entry.
  - A simultaneous input and output transfer keeps the occupancy unchanged.
- Address counter: out_addr is attached to each word at encode time. The counter increments by 1 per accepted input and wraps from 2^ADDR_W-1 to 0.
- Field placement; unused bit positions take the field from the list below, else 0:
  - R: f7, rs2, rs1, f3, rd, op.
  - I: instr[31:20]=imm[11:0]; rs1, f3, rd, op.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]; rs2, rs1, f3, op.
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; rs2, rs1, f3, op.
  - U: [31:12]=imm[31:12]; rd, op.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; rd, op.
- Illegal fmt (6 or 7): encoded as R, with out_err=1 regardless of the macro.
- All outputs of a word (out_instr, out_addr, out_err) travel together through the buffer.
- Outputs hold stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: SR_ENCODE_IMM_CHECK_EN.
- Defined: out_err=1 when the immediate is not representable. Rules per format:
  - I/S: imm must sign-extend from bit 11.
  - B: must sign-extend from bit 12, and imm[0] must be 0.
  - J: must sign-extend from bit 20, and imm[0] must be 0.
  - U: imm[11:0] must be 0.
  - R: imm is ignored.
- The word is still encoded by truncation and still delivered.
- Undefined: immediate bits are silently truncated; out_err reflects only an illegal fmt.

Test Plan:
- fmt=I, op=0x13, rd=1, rs1=0, f3=0, imm=5, out_ready=1 -> next cycle out_instr=0x00500093, out_addr=0, out_err=0.
- fmt=R, op=0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> out_instr=0x002081B3. fmt=B, op=0x63, rs1=1, rs2=2, f3=0, imm=-4 -> out_instr=0xFE208EE3.
- fmt=U, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7. fmt=J, op=0x6F, rd=1, imm=8 -> 0x008000EF.
- Stream 4 words with out_ready=0 after the first:
  - in_ready falls after 2 words are held.
  - On raising out_ready, the words emerge in order with out_addr 0,1,2,3.
- With the macro defined: fmt=I, imm=2048 -> out_err=1, out_instr[31:20]=0x800. fmt=B, imm=3 -> out_err=1. fmt=6 -> out_err=1 with or without the macro.
- ADDR_W=2: stream 5 words -> out_addr 0,1,2,3,0. Assert rst while 2 words are buffered -> next cycle out_valid=0, in_ready=1, out_addr=ADDR_START.
